bind_op_scheduler: RTL and testbench

BIND_OP_SCHEDULER -- requirements
Module: bind_op_scheduler

---
 rtl/bind_op_scheduler.sv | 143 ++++++++++++++
 tb/tb_bind_op_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bind_op_scheduler.sv
// Round-robin scheduler that serialises bind requests from several requesters onto
// one kernel generator and returns a completion pulse (optionally forced by timeout).
module bind_op_scheduler #(
    parameter int HV_ADDRESS_WIDTH = 20,
    parameter int NUM_REQ          = 4,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int IDW              = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_hva,
    input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_hvb,
    input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_hvc,
    input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_offset,
    output logic [NUM_REQ-1:0]                  ack,
    output logic                                timeout_err,
    output logic                                busy,
    output logic [IDW-1:0]                      active_id,
    output logic                                k_valid,
    output logic [HV_ADDRESS_WIDTH-1:0]         k_hva,
    output logic [HV_ADDRESS_WIDTH-1:0]         k_hvb,
    output logic [HV_ADDRESS_WIDTH-1:0]         k_hvc,
    output logic [HV_ADDRESS_WIDTH-1:0]         k_offset,
    input  logic                                k_done
);

    localparam int AW = HV_ADDRESS_WIDTH;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]      CNT_TERM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    state_t              state_reg;
    logic [IDW-1:0]      rr_ptr_reg;
    logic [IDW-1:0]      active_id_reg;
    logic [CW-1:0]       cnt_reg;
    logic [NUM_REQ-1:0]  ack_reg;
    logic                timeout_err_reg;
    logic                busy_reg;
    logic                k_valid_reg;
    logic [AW-1:0]       k_hva_reg, k_hvb_reg, k_hvc_reg, k_offset_reg;

    logic [AW-1:0]       hva_arr    [NUM_REQ];
    logic [AW-1:0]       hvb_arr    [NUM_REQ];
    logic [AW-1:0]       hvc_arr    [NUM_REQ];
    logic [AW-1:0]       offset_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  upper_req, sel_req, first_req;
    logic [IDW-1:0]      idx_chain  [NUM_REQ+1];
    logic [IDW-1:0]      grant_idx;

    // Wrap-around priority: prefer requests at or above rr_ptr, else the lowest one.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign hva_arr[gi]      = req_hva[gi*AW +: AW];
            assign hvb_arr[gi]      = req_hvb[gi*AW +: AW];
            assign hvc_arr[gi]      = req_hvc[gi*AW +: AW];
            assign offset_arr[gi]   = req_offset[gi*AW +: AW];
            assign upper_req[gi]    = req[gi] && (gi >= int'(rr_ptr_reg));
            assign idx_chain[gi+1]  = idx_chain[gi] | (first_req[gi] ? IDW'(gi) : '0);
        end
    endgenerate

    assign idx_chain[0] = '0;
    assign sel_req      = (|upper_req) ? upper_req : req;
    assign first_req    = sel_req & (~sel_req + REQ_ONE);
    assign grant_idx    = idx_chain[NUM_REQ];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            rr_ptr_reg      <= '0;
            active_id_reg   <= '0;
            cnt_reg         <= '0;
            ack_reg         <= '0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
            k_valid_reg     <= 1'b0;
            k_hva_reg       <= '0;
            k_hvb_reg       <= '0;
            k_hvc_reg       <= '0;
            k_offset_reg    <= '0;
        end else begin
            k_valid_reg     <= 1'b0;
            ack_reg         <= '0;
            timeout_err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (|req) begin
                        active_id_reg <= grant_idx;
                        k_hva_reg     <= hva_arr[grant_idx];
                        k_hvb_reg     <= hvb_arr[grant_idx];
                        k_hvc_reg     <= hvc_arr[grant_idx];
                        k_offset_reg  <= offset_arr[grant_idx];
                        k_valid_reg   <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the terminal-count cycle wins over the timeout.
                    if (k_done) begin
                        ack_reg   <= REQ_ONE << active_id_reg;
                        state_reg <= S_RELEASE;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_reg == CNT_TERM) begin
                        ack_reg         <= REQ_ONE << active_id_reg;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= S_RELEASE;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_RELEASE: begin
                    rr_ptr_reg <= (active_id_reg == IDW'(NUM_REQ - 1)) ? '0
                                                                       : active_id_reg + IDW'(1);
                    busy_reg   <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_reg;
    assign timeout_err = timeout_err_reg;
    assign busy        = busy_reg;
    assign active_id   = active_id_reg;
    assign k_valid     = k_valid_reg;
    assign k_hva       = k_hva_reg;
    assign k_hvb       = k_hvb_reg;
    assign k_hvc       = k_hvc_reg;
    assign k_offset    = k_offset_reg;

endmodule

// File: tb/tb_bind_op_scheduler.sv
// Bench for bind_op_scheduler: fixed vector table, hand-written round-robin and
// reset sequences, then random transactions checked against a transaction-level model.
module tb_bind_op_scheduler;

    localparam int AW = 20;
    localparam int N  = 4;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_hva, req_hvb, req_hvc, req_offset;
    logic [N-1:0]    ack;
    logic            timeout_err, busy, k_valid, k_done;
    logic [1:0]      active_id;
    logic [AW-1:0]   k_hva, k_hvb, k_hvc, k_offset;

    int checks = 0;
    int errors = 0;

    bind_op_scheduler #(
        .HV_ADDRESS_WIDTH (AW),
        .NUM_REQ          (N),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_hva     (req_hva),
        .req_hvb     (req_hvb),
        .req_hvc     (req_hvc),
        .req_offset  (req_offset),
        .ack         (ack),
        .timeout_err (timeout_err),
        .busy        (busy),
        .active_id   (active_id),
        .k_valid     (k_valid),
        .k_hva       (k_hva),
        .k_hvb       (k_hvb),
        .k_hvc       (k_hvc),
        .k_offset    (k_offset),
        .k_done      (k_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  req;
        int            d;          // k_done cycle index relative to the k_valid cycle
        logic [AW-1:0] a, b, c, o;
        int            exp_id;
        int            exp_lat;    // cycles from k_valid to ack
        bit            exp_terr;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        k_done  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " k_valid"},     k_valid, 0);
        check({tag, " ack"},         ack, 0);
        check({tag, " busy"},        busy, 0);
        check({tag, " timeout_err"}, timeout_err, 0);
        check({tag, " active_id"},   active_id, 0);
        check({tag, " k_ops"},       {k_hva, k_hvb, k_hvc, k_offset}, 0);
    endtask

    // Granted slice carries the given operands, every other slice a distinct decoy.
    task automatic set_ops(input int gid, input logic [AW-1:0] a, b, c, o);
        for (int i = 0; i < N; i++) begin
            logic [AW-1:0] pert;
            pert = AW'(32'h11111 * (i + 1));
            if (i == gid) begin
                req_hva[i*AW +: AW]    = a;
                req_hvb[i*AW +: AW]    = b;
                req_hvc[i*AW +: AW]    = c;
                req_offset[i*AW +: AW] = o;
            end else begin
                req_hva[i*AW +: AW]    = a ^ pert;
                req_hvb[i*AW +: AW]    = b ^ pert;
                req_hvc[i*AW +: AW]    = c ^ pert;
                req_offset[i*AW +: AW] = o ^ pert;
            end
        end
    endtask

    task automatic issue_txn(input string tag, input logic [N-1:0] req_v, input int exp_id,
                             input logic [AW-1:0] a, b, c, o);
        set_ops(exp_id, a, b, c, o);
        req = req_v;
        tick();
        check({tag, " k_valid"},   k_valid, 1);
        check({tag, " busy"},      busy, 1);
        check({tag, " active_id"}, active_id, exp_id);
        check({tag, " k_ops"},     {k_hva, k_hvb, k_hvc, k_offset}, {a, b, c, o});
        check({tag, " ack_idle"},  ack, 0);
    endtask

    task automatic complete_txn(input string tag, input int exp_id, input int d,
                                input int exp_lat, input bit exp_terr,
                                input logic [AW-1:0] a, b, c, o, input logic [N-1:0] req_after);
        int lat;
        lat = 0;
        for (int j = 0; j < 20; j++) begin
            k_done = (j == d);
            tick();
            k_done     = 1'b0;
            req_hva    = (N*AW)'({$urandom(), $urandom(), $urandom()});
            req_hvb    = (N*AW)'({$urandom(), $urandom(), $urandom()});
            req_hvc    = (N*AW)'({$urandom(), $urandom(), $urandom()});
            req_offset = (N*AW)'({$urandom(), $urandom(), $urandom()});
            if (ack != '0) begin
                lat = j + 1;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s ack_wait: no ack within 20 cycles, expected ack after %0d", tag, exp_lat);
        end else begin
            check({tag, " latency"},     lat, exp_lat);
            check({tag, " ack"},         ack, 4'b0001 << exp_id);
            check({tag, " timeout_err"}, timeout_err, exp_terr);
            check({tag, " kv_with_ack"}, k_valid, 0);
            check({tag, " k_hold"},      {k_hva, k_hvb, k_hvc, k_offset}, {a, b, c, o});
            check({tag, " id_hold"},     active_id, exp_id);
        end
        req = req_after;
        tick();
        check({tag, " ack_pulse"}, ack, 0);
        check({tag, " idle_busy"}, busy, 0);
        $display("txn %s: id=%0d lat=%0d terr=%0b", tag, active_id, lat, exp_terr);
    endtask

    task automatic do_txn(input string tag, input logic [N-1:0] req_v, input int exp_id,
                          input int d, input int exp_lat, input bit exp_terr,
                          input logic [AW-1:0] a, b, c, o, input logic [N-1:0] req_after);
        issue_txn(tag, req_v, exp_id, a, b, c, o);
        complete_txn(tag, exp_id, d, exp_lat, exp_terr, a, b, c, o, req_after);
    endtask

    // Reference arbitration: first asserted requester walking up from ptr with wrap.
    function automatic int model_grant(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (((r >> i) & 4'b0001) != 0) return i;
        end
        return -1;
    endfunction

    initial begin
        vecs[0] = '{4'b0100, 5, 20'h00010, 20'h00020, 20'h00030, 20'h00004, 2, 6, 1'b0};
        vecs[1] = '{4'b1111, 2, 20'hABCDE, 20'h12345, 20'h0F0F0, 20'h00001, 3, 3, 1'b0};
        vecs[2] = '{4'b1111, 1, 20'hFFFFF, 20'h00000, 20'h55555, 20'hAAAAA, 0, 2, 1'b0};
        vecs[3] = '{4'b0101, 0, 20'h13579, 20'h2468A, 20'h0BEEF, 20'h00010, 2, 9, 1'b1};
        vecs[4] = '{4'b0011, 8, 20'h00100, 20'h00200, 20'h00300, 20'h00040, 0, 9, 1'b0};
        vecs[5] = '{4'b0001, 9, 20'hC0DE0, 20'hFACE0, 20'hBEAD0, 20'h00008, 0, 9, 1'b1};
        vecs[6] = '{4'b1000, 3, 20'h7FFFF, 20'h80000, 20'h00FFF, 20'hFF000, 3, 4, 1'b0};
        vecs[7] = '{4'b0110, 7, 20'h31415, 20'h92653, 20'h58979, 20'h32384, 1, 8, 1'b0};

        reset_n = 1'b0; req = '0; k_done = 1'b0;
        req_hva = '0; req_hvb = '0; req_hvc = '0; req_offset = '0;
        do_reset();
        check_reset_outputs("reset");

        for (int v = 0; v < 8; v++) begin
            do_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].exp_id, vecs[v].d,
                   vecs[v].exp_lat, vecs[v].exp_terr,
                   vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].o, 4'b0000);
        end

        // Round robin with all requesters held, each dropping after its own ack.
        do_reset();
        do_txn("rr0", 4'b1111, 0, 3, 4, 1'b0, 20'h00001, 20'h00002, 20'h00003, 20'h00004, 4'b1110);
        do_txn("rr1", 4'b1110, 1, 3, 4, 1'b0, 20'h00011, 20'h00012, 20'h00013, 20'h00014, 4'b1100);
        do_txn("rr2", 4'b1100, 2, 3, 4, 1'b0, 20'h00021, 20'h00022, 20'h00023, 20'h00024, 4'b1000);
        do_txn("rr3", 4'b1000, 3, 3, 4, 1'b0, 20'h00031, 20'h00032, 20'h00033, 20'h00034, 4'b0000);
        do_txn("rr4", 4'b0101, 0, 2, 3, 1'b0, 20'h00041, 20'h00042, 20'h00043, 20'h00044, 4'b0000);

        // Reset while waiting on the kernel: no ack, then a fresh grant from pointer 0.
        issue_txn("rstw", 4'b0010, 1, 20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'h0DDDD);
        tick();
        tick();
        check("rstw no_ack_wait", ack, 0);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("rstw");
        set_ops(1, 20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'h0DDDD);
        reset_n = 1'b1;
        tick();
        check("rstw regrant k_valid", k_valid, 1);
        check("rstw regrant id", active_id, 1);
        check("rstw regrant ops", {k_hva, k_hvb, k_hvc, k_offset},
              {20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'h0DDDD});
        complete_txn("rstw", 1, 2, 3, 1'b0, 20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'h0DDDD, 4'b0000);

        // Random transactions against the transaction-level model.
        do_reset();
        begin
            int rr_model;
            rr_model = 0;
            for (int t = 0; t < 40; t++) begin
                logic [N-1:0]  r;
                logic [AW-1:0] a, b, c, o;
                int d, gid, lat;
                bit terr;
                r    = N'($urandom_range(1, 15));
                d    = $urandom_range(0, 11);
                a    = AW'($urandom());
                b    = AW'($urandom());
                c    = AW'($urandom());
                o    = AW'($urandom());
                gid  = model_grant(r, rr_model);
                terr = !(d >= 1 && d <= 8);
                lat  = terr ? 9 : d + 1;
                do_txn($sformatf("rnd%0d", t), r, gid, d, lat, terr, a, b, c, o, 4'b0000);
                rr_model = (gid + 1) % N;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
